// File: rtl/cpu_dev_pkg.sv
// Shared definitions for memory-mapped CPU devices: register offsets,
// CTRL field positions, mode encodings and the timer FSM state type.
package cpu_dev_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } timer_ctrl_t;

  // Only the exact auto-reload encoding reloads; every other MODE is one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// Word-addressed device bus between the CPU bridge (master) and a device (slave).
interface timer_dev_if;
  logic [3:2]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output addr, output we, output din, input dout);
  modport slave  (input addr, input we, input din, output dout);
endinterface

// File: rtl/timer_dev.sv
// Programmable count-down timer with one-shot / auto-reload modes; irq feeds HWInt[2].
module timer_dev
  import cpu_dev_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  timer_dev_if.slave  bus,
  output logic        irq
);

  timer_state_e state_q, state_d;
  timer_ctrl_t  ctrl_q;
  logic [31:0]  preset_q;
  logic [31:0]  count_q, count_d;
  logic         irq_pend;
  logic         wr_ctrl, wr_preset, reload;
  logic         clr_en, set_pend, clr_pend_reload;

  assign wr_ctrl   = bus.we && (bus.addr == REG_CTRL);
  assign wr_preset = bus.we && (bus.addr == REG_PRESET);
  assign reload    = is_reload(ctrl_q.mode);
  assign irq       = irq_pend & ctrl_q.im;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    clr_en          = 1'b0;
    set_pend        = 1'b0;
    clr_pend_reload = 1'b0;
    case (state_q)
      ST_IDLE: if (ctrl_q.en) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Covers both COUNT==1 and a zero preset; COUNT saturates at 0.
          count_d  = '0;
          state_d  = ST_INT;
          set_pend = 1'b1;
        end
      end
      ST_INT: begin
        if (reload) begin
          state_d         = ST_LOAD;
          clr_pend_reload = 1'b1;
        end else begin
          state_d = ST_IDLE;
          clr_en  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A bus write to CTRL wins over the FSM clearing EN in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
    end else if (wr_ctrl) begin
      ctrl_q <= '{im:   bus.din[CTRL_IM_BIT],
                  mode: bus.din[CTRL_MODE_LSB +: 2],
                  en:   bus.din[CTRL_EN_BIT]};
    end else if (clr_en) begin
      ctrl_q.en <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) preset_q <= '0;
    else if (wr_preset) preset_q <= bus.din;
  end

  // Setting the pending flag wins over any clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pend <= 1'b0;
    end else if (set_pend) begin
      irq_pend <= 1'b1;
    end else if (clr_pend_reload) begin
      irq_pend <= 1'b0;
    end else if (!reload && (wr_ctrl || wr_preset)) begin
      irq_pend <= 1'b0;
    end
  end

  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      REG_CTRL:   bus.dout[3:0] = ctrl_q;
      REG_PRESET: bus.dout      = preset_q;
      REG_COUNT:  bus.dout      = count_q;
      default:    bus.dout      = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: reset, one-shot, auto-reload, mask, stop/restart, collisions.
module tb_timer_dev;
  import cpu_dev_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic irq;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] d;

  timer_dev_if bus ();

  timer_dev dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at/near a negedge; the write lands on the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    bus.addr = a;
    bus.din  = v;
    bus.we   = 1'b1;
    @(negedge clk);
    bus.we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1 v = bus.dout;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected 00000000", a, d);
      end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    // Reset in the middle of a count, then confirm the FSM stays idle.
    wr(REG_PRESET, 32'd20);
    wr(REG_CTRL, 32'h9);
    tick(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL midreset_reg%0d: got %h expected 00000000", a, d);
      end
    end
    tick(3);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midreset_idle_count: got %h expected 0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_oneshot();
    do_reset();
    wr(REG_PRESET, 32'd5);
    wr(REG_CTRL, 32'h9);
    tick(6);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL oneshot_count_e6: got %0d expected 1", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_e6: got %b expected 0", irq); end
    tick(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_e7: got %b expected 1", irq); end
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL oneshot_count_e7: got %0d expected 0", d); end
    tick(1);
    rd(REG_CTRL, d);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL oneshot_ctrl_e8: got %h expected 8", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_e8: got %b expected 1", irq); end
    tick(3);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_held: got %b expected 1", irq); end
    wr(REG_CTRL, 32'h8);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_cleared: got %b expected 0", irq); end
  endtask

  task automatic test_reload();
    logic exp;
    do_reset();
    wr(REG_PRESET, 32'd3);
    wr(REG_CTRL, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      tick(1);
      exp = (k >= 5) && (((k - 5) % 5) == 0);
      checks++;
      if (irq !== exp) begin
        errors++;
        $display("FAIL reload_irq_e%0d: got %b expected %b", k, irq, exp);
      end
    end
  endtask

  task automatic test_mask();
    do_reset();
    wr(REG_PRESET, 32'd2);
    wr(REG_CTRL, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_e%0d: got %b expected 0", k, irq); end
    end
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL mask_count: got %0d expected 0", d); end
    wr(REG_CTRL, 32'h8);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_unmask_irq: got %b expected 0", irq); end
    tick(2);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_unmask_irq_later: got %b expected 0", irq); end
  endtask

  task automatic test_stop_restart();
    do_reset();
    wr(REG_PRESET, 32'd10);
    wr(REG_CTRL, 32'h9);
    tick(5);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'd7) begin errors++; $display("FAIL stop_count_e5: got %0d expected 7", d); end
    wr(REG_CTRL, 32'h8);
    tick(3);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'd6) begin errors++; $display("FAIL stop_count_held: got %0d expected 6", d); end
    wr(REG_PRESET, 32'd4);
    wr(REG_CTRL, 32'h9);
    tick(2);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL restart_count_reload: got %0d expected 4", d); end
    tick(3);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL restart_irq_f5: got %b expected 0", irq); end
    tick(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL restart_irq_f6: got %b expected 1", irq); end
  endtask

  task automatic test_collision();
    // CTRL write on the INT-entry edge.
    do_reset();
    wr(REG_PRESET, 32'd2);
    wr(REG_CTRL, 32'h9);
    tick(3);
    wr(REG_CTRL, 32'h9);
    rd(REG_CTRL, d);
    checks++;
    if (d !== 32'h9) begin errors++; $display("FAIL coll_entry_ctrl: got %h expected 9", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL coll_entry_irq: got %b expected 1", irq); end
    tick(1);
    rd(REG_CTRL, d);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL coll_entry_ctrl_after: got %h expected 8", d); end
    // CTRL write on the INT-exit edge keeps EN and restarts the count.
    do_reset();
    wr(REG_PRESET, 32'd2);
    wr(REG_CTRL, 32'h9);
    tick(4);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL coll_exit_irq_e4: got %b expected 1", irq); end
    wr(REG_CTRL, 32'h9);
    rd(REG_CTRL, d);
    checks++;
    if (d !== 32'h9) begin errors++; $display("FAIL coll_exit_ctrl: got %h expected 9", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL coll_exit_irq: got %b expected 0", irq); end
    tick(2);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL coll_exit_reload: got %0d expected 2", d); end
    tick(2);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL coll_exit_irq_again: got %b expected 1", irq); end
  endtask

  task automatic test_zero_preset();
    do_reset();
    wr(REG_PRESET, 32'd0);
    wr(REG_CTRL, 32'h9);
    tick(2);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL zero_irq_e2: got %b expected 0", irq); end
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL zero_count_e2: got %0d expected 0", d); end
    tick(1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL zero_irq_e3: got %b expected 1", irq); end
  endtask

  task automatic test_regs();
    do_reset();
    wr(REG_PRESET, 32'hDEADBEEF);
    rd(REG_PRESET, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL regs_preset: got %h expected deadbeef", d); end
    wr(REG_CTRL, 32'hFFFFFFF6);
    rd(REG_CTRL, d);
    checks++;
    if (d !== 32'h6) begin errors++; $display("FAIL regs_ctrl_upper: got %h expected 6", d); end
    wr(REG_COUNT, 32'h1234);
    rd(REG_COUNT, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL regs_count_ro: got %h expected 0", d); end
    wr(2'd3, 32'hFFFFFFFF);
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL regs_reserved: got %h expected 0", d); end
    // MODE=10 behaves as one-shot.
    do_reset();
    wr(REG_PRESET, 32'd1);
    wr(REG_CTRL, 32'hD);
    tick(3);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL mode10_irq_e3: got %b expected 1", irq); end
    tick(1);
    rd(REG_CTRL, d);
    checks++;
    if (d !== 32'hC) begin errors++; $display("FAIL mode10_ctrl_e4: got %h expected c", d); end
    tick(3);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL mode10_irq_held: got %b expected 1", irq); end
  endtask

  initial begin
    rst      = 1'b1;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.din  = '0;
    test_reset();
    test_oneshot();
    test_reload();
    test_mask();
    test_stop_restart();
    test_collision();
    test_zero_preset();
    test_regs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
